pool_result_reader: RTL and testbench

- Read-side initiator for the pooling block's inference port. Once the pooling block raises done, this block sweeps infer_addr from 0 to OUTSIZE-1.
- It waits out the output BRAM's read latency, then presents each pooled byte on a valid/ready stream to downstream logic (classifier, UART tx).
- It also reports a 16-bit running byte sum for quick result checking.

---
 rtl/pool_pkg.sv | 20 ++
 rtl/pool_result_reader.sv | 133 +++++++++++++
 tb/tb_pool_result_reader.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the pooling block's result reader: FSM encoding and
// the default pooling geometry used to size the output sweep.
package pool_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_DONE = 3'd1,
      S_ADDR      = 3'd2,
      S_LAT       = 3'd3,
      S_PRESENT   = 3'd4,
      S_FINISH    = 3'd5
   } state_e;

   localparam int INP_X       = 7;
   localparam int K           = 3;
   localparam int STRIDE      = 2;
   localparam int OUT_DIM     = (INP_X - K) / STRIDE + 1;
   localparam int OUTSIZE_DEF = OUT_DIM * OUT_DIM;

endpackage

// File: rtl/pool_result_reader.sv
// Sweeps the pooling block's output BRAM once pool_done is seen and streams
// each pooled byte over valid/ready, keeping a 16-bit running byte sum.
module pool_result_reader
   import pool_pkg::*;
#(
   parameter int OUTSIZE = OUTSIZE_DEF,
   parameter int RD_LAT  = 2,
   parameter int DW      = 8,
   parameter int AW      = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          pool_done,
   output logic [AW-1:0] infer_addr,
   input  logic [DW-1:0] infer_dout,
   output logic [DW-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_last,
   output logic          busy,
   output logic          finished,
   output logic [15:0]   sum
);

   localparam int          LW       = $clog2(RD_LAT + 2);
   localparam logic [AW-1:0] LAST_IDX = AW'(OUTSIZE - 1);

   if (OUTSIZE < 1 || longint'(OUTSIZE) > (longint'(1) << AW)) begin : g_bad_outsize
      $error("pool_result_reader: OUTSIZE must lie in 1..2**AW");
   end

   state_e          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [LW-1:0]   lat_q, lat_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_q, data_d;
   logic            valid_q, valid_d;
   logic            last_q, last_d;
   logic            fin_q, fin_d;
   logic [15:0]     sum_q, sum_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         lat_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         fin_q   <= 1'b0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lat_q   <= lat_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         fin_q   <= fin_d;
         sum_q   <= sum_d;
      end
   end

   // One read outstanding at a time: ADDR -> LAT (RD_LAT+1 cycles) -> PRESENT.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      lat_d   = lat_q;
      addr_d  = addr_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      fin_d   = 1'b0;
      sum_d   = sum_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = '0;
               sum_d   = '0;
               addr_d  = '0;
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (pool_done) state_d = S_ADDR;
         end
         S_ADDR: begin
            addr_d  = idx_q;
            lat_d   = '0;
            state_d = S_LAT;
         end
         S_LAT: begin
            lat_d = lat_q + 1'b1;
            if (lat_q == LW'(RD_LAT)) begin
               data_d  = infer_dout;
               valid_d = 1'b1;
               last_d  = (idx_q == LAST_IDX);
               state_d = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (m_ready) begin
               valid_d = 1'b0;
               sum_d   = sum_q + 16'(data_q);
               if (idx_q == LAST_IDX) begin
                  state_d = S_FINISH;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_ADDR;
               end
            end
         end
         S_FINISH: begin
            fin_d   = 1'b1;
            last_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign infer_addr = addr_q;
   assign m_data     = data_q;
   assign m_valid    = valid_q;
   assign m_last     = last_q;
   assign finished   = fin_q;
   assign sum        = sum_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_pool_result_reader.sv
// Bench for pool_result_reader: three instances (OUTSIZE 9, 300, 1) each fed
// by a two-stage BRAM model; streams are compared to memory contents.
module tb_pool_result_reader;

   localparam int NA = 9;
   localparam int NB = 300;
   localparam int NC = 1;
   localparam int BEAT_GAP = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- instance A (OUTSIZE=9) ----------------
   logic        start_a = 0, done_a = 0, ready_a = 0;
   logic [15:0] addr_a, sum_a;
   logic [7:0]  dout_a, data_a;
   logic        valid_a, last_a, busy_a, fin_a;
   logic [7:0]  mem_a [NA];
   logic [15:0] ar_a = '0;

   pool_result_reader #(.OUTSIZE(NA), .RD_LAT(2), .DW(8), .AW(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .pool_done(done_a),
      .infer_addr(addr_a), .infer_dout(dout_a), .m_data(data_a), .m_valid(valid_a),
      .m_ready(ready_a), .m_last(last_a), .busy(busy_a), .finished(fin_a), .sum(sum_a));

   always @(posedge clk) begin
      ar_a   <= addr_a;
      dout_a <= (ar_a < NA) ? mem_a[ar_a] : 8'h00;
   end

   logic [7:0] q_data[$];
   logic       q_last[$];
   int         q_cyc[$];
   int         fin_cnt_a = 0, stall_err_a = 0, range_err_a = 0;
   logic       pv = 0, pl = 0;
   logic [7:0] pd = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         pv <= 1'b0;
      end else begin
         if (pv && (valid_a !== 1'b1 || data_a !== pd || last_a !== pl))
            stall_err_a <= stall_err_a + 1;
         if (valid_a && ready_a) begin
            q_data.push_back(data_a);
            q_last.push_back(last_a);
            q_cyc.push_back(cyc);
         end
         pv <= valid_a && !ready_a;
         pd <= data_a;
         pl <= last_a;
         if (fin_a) fin_cnt_a <= fin_cnt_a + 1;
         if (addr_a >= NA) range_err_a <= range_err_a + 1;
      end
   end

   // ---------------- instance B (OUTSIZE=300, all 0xFF) ----------------
   logic        start_b = 0, done_b = 0, ready_b = 0;
   logic [15:0] addr_b, sum_b;
   logic [7:0]  dout_b, data_b;
   logic        valid_b, last_b, busy_b, fin_b;
   logic [15:0] ar_b = '0;
   int          n_b = 0, lc_b = 0, li_b = -1;

   pool_result_reader #(.OUTSIZE(NB), .RD_LAT(2), .DW(8), .AW(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .pool_done(done_b),
      .infer_addr(addr_b), .infer_dout(dout_b), .m_data(data_b), .m_valid(valid_b),
      .m_ready(ready_b), .m_last(last_b), .busy(busy_b), .finished(fin_b), .sum(sum_b));

   always @(posedge clk) begin
      ar_b   <= addr_b;
      dout_b <= (ar_b < NB) ? 8'hFF : 8'h00;
   end

   always @(negedge clk) begin
      if (rst_n && valid_b && ready_b) begin
         n_b <= n_b + 1;
         if (last_b) begin
            lc_b <= lc_b + 1;
            li_b <= n_b;
         end
      end
   end

   // ---------------- instance C (OUTSIZE=1) ----------------
   logic        start_c = 0, done_c = 0, ready_c = 0;
   logic [15:0] addr_c, sum_c;
   logic [7:0]  dout_c, data_c;
   logic        valid_c, last_c, busy_c, fin_c;
   logic [15:0] ar_c = '0;
   logic [7:0]  mem_c = 8'h00;
   logic [7:0]  d_c = 8'h00;
   int          n_c = 0, lc_c = 0;

   pool_result_reader #(.OUTSIZE(NC), .RD_LAT(2), .DW(8), .AW(16)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .pool_done(done_c),
      .infer_addr(addr_c), .infer_dout(dout_c), .m_data(data_c), .m_valid(valid_c),
      .m_ready(ready_c), .m_last(last_c), .busy(busy_c), .finished(fin_c), .sum(sum_c));

   always @(posedge clk) begin
      ar_c   <= addr_c;
      dout_c <= (ar_c < NC) ? mem_c : 8'h00;
   end

   always @(negedge clk) begin
      if (rst_n && valid_c && ready_c) begin
         n_c <= n_c + 1;
         d_c <= data_c;
         if (last_c) lc_c <= lc_c + 1;
      end
   end

   // Reference: the stream is just memory in address order; sum is mod 2^16.
   function automatic int model_sum_a();
      int s = 0;
      for (int i = 0; i < NA; i++) s += mem_a[i];
      return s % 65536;
   endfunction

   task automatic clear_a();
      q_data.delete();
      q_last.delete();
      q_cyc.delete();
   endtask

   // Runs one sweep on A; rmode 0 = ready held high, 1 = random stalls.
   task automatic run_a(input bit do_start, input int rmode, input bit poke, output bit ok);
      ok = 1'b0;
      if (do_start) begin
         start_a = 1'b1;
         @(posedge clk); #1;
         start_a = 1'b0;
      end
      for (int i = 0; i < 3000 && !ok; i++) begin
         ready_a = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
         if (poke) start_a = busy_a ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk); #1;
         if (fin_a === 1'b1) ok = 1'b1;
      end
      start_a = 1'b0;
      @(negedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({addr_a, data_a, valid_a, last_a, busy_a, fin_a, sum_a} !== '0) begin
         errors++;
         $display("FAIL reset_a: got addr=%0d data=%0d v=%b l=%b busy=%b fin=%b sum=%0d, want all 0",
                  addr_a, data_a, valid_a, last_a, busy_a, fin_a, sum_a);
      end
      checks++;
      if ({addr_b, sum_b, valid_b, busy_b, addr_c, sum_c, valid_c, busy_c} !== '0) begin
         errors++;
         $display("FAIL reset_bc: got addr_b=%0d sum_b=%0d busy_b=%b addr_c=%0d busy_c=%b, want all 0",
                  addr_b, sum_b, busy_b, addr_c, busy_c);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_wait_then_stream();
      int bad = 0;
      bit ok;
      for (int i = 0; i < NA; i++) mem_a[i] = 8'(10 + i);
      done_a = 1'b0;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (busy_a !== 1'b1 || addr_a !== 16'd0 || valid_a !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL wait_done_hold: %0d bad cycles, want 0 (busy=1 addr=0 valid=0)", bad);
      end
      clear_a();
      done_a = 1'b1;
      run_a(1'b0, 0, 1'b0, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL stream_timeout: finished=0, want 1 within bound");
      end
      bad = 0;
      for (int i = 0; i < q_data.size(); i++)
         if (q_data[i] !== mem_a[i] || q_last[i] !== (i == NA - 1)) bad++;
      checks++;
      if (q_data.size() != NA || bad != 0) begin
         errors++;
         $display("FAIL stream_order: beats=%0d bad=%0d, want beats=%0d bad=0", q_data.size(), bad, NA);
      end
      bad = 0;
      for (int i = 1; i < q_cyc.size(); i++)
         if (q_cyc[i] - q_cyc[i-1] != BEAT_GAP) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL beat_spacing: %0d gaps off, want all %0d cycles", bad, BEAT_GAP);
      end
      checks++;
      if (sum_a !== 16'(model_sum_a()) || sum_a !== 16'd126) begin
         errors++;
         $display("FAIL stream_sum: got %0d want %0d", sum_a, model_sum_a());
      end
      checks++;
      if (fin_cnt_a != 1) begin
         errors++;
         $display("FAIL finished_pulses: got %0d want 1", fin_cnt_a);
      end
   endtask

   task automatic test_stall();
      int bad = 0;
      bit ok;
      int f0 = fin_cnt_a;
      clear_a();
      run_a(1'b1, 1, 1'b0, ok);
      for (int i = 0; i < q_data.size(); i++)
         if (q_data[i] !== mem_a[i] || q_last[i] !== (i == NA - 1)) bad++;
      checks++;
      if (!ok || q_data.size() != NA || bad != 0) begin
         errors++;
         $display("FAIL stall_order: ok=%b beats=%0d bad=%0d, want ok=1 beats=%0d bad=0", ok, q_data.size(), bad, NA);
      end
      checks++;
      if (stall_err_a != 0) begin
         errors++;
         $display("FAIL stall_stable: %0d unstable stalled cycles, want 0", stall_err_a);
      end
      checks++;
      if (sum_a !== 16'(model_sum_a()) || fin_cnt_a != f0 + 1) begin
         errors++;
         $display("FAIL stall_sum: sum=%0d fin=%0d, want sum=%0d fin=%0d", sum_a, fin_cnt_a - f0, model_sum_a(), 1);
      end
   endtask

   task automatic test_random_busy_start();
      int bad = 0;
      bit ok;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NA; i++) mem_a[i] = 8'($urandom);
         clear_a();
         run_a(1'b1, 1, 1'b1, ok);
         bad = 0;
         for (int i = 0; i < q_data.size(); i++)
            if (q_data[i] !== mem_a[i] || q_last[i] !== (i == NA - 1)) bad++;
         checks++;
         if (!ok || q_data.size() != NA || bad != 0 || sum_a !== 16'(model_sum_a())) begin
            errors++;
            $display("FAIL busy_start_r%0d: beats=%0d bad=%0d sum=%0d, want beats=%0d bad=0 sum=%0d",
                     r, q_data.size(), bad, sum_a, NA, model_sum_a());
         end
      end
      checks++;
      if (stall_err_a != 0 || range_err_a != 0) begin
         errors++;
         $display("FAIL addr_range: stall_err=%0d range_err=%0d, want 0 0", stall_err_a, range_err_a);
      end
   endtask

   task automatic test_start_with_done();
      bit ok = 0;
      logic v5;
      for (int i = 0; i < NA; i++) mem_a[i] = 8'(10 + i);
      done_a  = 1'b1;
      ready_a = 1'b1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (4) @(posedge clk);
      #1 v5 = valid_a;
      @(posedge clk); #1;
      checks++;
      if (v5 !== 1'b0 || valid_a !== 1'b1 || data_a !== mem_a[0]) begin
         errors++;
         $display("FAIL start_with_done: valid@5=%b valid@6=%b data=%0d, want 0 1 %0d", v5, valid_a, data_a, mem_a[0]);
      end
      for (int i = 0; i < 200 && !ok; i++) begin
         @(posedge clk); #1;
         if (fin_a === 1'b1) ok = 1'b1;
      end
      checks++;
      if (!ok || sum_a !== 16'(model_sum_a())) begin
         errors++;
         $display("FAIL start_with_done_end: fin=%b sum=%0d, want 1 %0d", ok, sum_a, model_sum_a());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit ok = 0;
      int f0;
      clear_a();
      ready_a = 1'b1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int i = 0; i < 200 && q_data.size() < 3; i++) begin
         @(posedge clk); #1;
      end
      f0 = fin_cnt_a;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({addr_a, data_a, valid_a, last_a, busy_a, fin_a, sum_a} !== '0 || q_data.size() != 3) begin
         errors++;
         $display("FAIL reset_mid: beats=%0d addr=%0d v=%b busy=%b sum=%0d, want beats=3 and outputs 0",
                  q_data.size(), addr_a, valid_a, busy_a, sum_a);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (fin_cnt_a != f0 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_quiet: fin pulses=%0d busy=%b, want 0 0", fin_cnt_a - f0, busy_a);
      end
      clear_a();
      run_a(1'b1, 0, 1'b0, ok);
      checks++;
      if (!ok || q_data.size() != NA || q_data[0] !== mem_a[0] || sum_a !== 16'(model_sum_a())) begin
         errors++;
         $display("FAIL restart: ok=%b beats=%0d sum=%0d, want ok=1 beats=%0d sum=%0d",
                  ok, q_data.size(), sum_a, NA, model_sum_a());
      end
   endtask

   task automatic test_outsize300();
      bit ok = 0;
      done_b  = 1'b1;
      ready_b = 1'b1;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(posedge clk); #1;
         if (fin_b === 1'b1) ok = 1'b1;
      end
      @(negedge clk); #1;
      checks++;
      if (!ok || n_b != NB) begin
         errors++;
         $display("FAIL big_beats: ok=%b beats=%0d, want 1 %0d", ok, n_b, NB);
      end
      checks++;
      if (sum_b !== 16'((NB * 255) % 65536)) begin
         errors++;
         $display("FAIL big_sum: got %0d want %0d", sum_b, (NB * 255) % 65536);
      end
      checks++;
      if (addr_b !== 16'(NB - 1) || lc_b != 1 || li_b != NB - 1) begin
         errors++;
         $display("FAIL big_last: addr=%0d lasts=%0d last_idx=%0d, want %0d 1 %0d", addr_b, lc_b, li_b, NB - 1, NB - 1);
      end
   endtask

   task automatic test_outsize1();
      bit ok = 0;
      mem_c   = 8'($urandom);
      done_c  = 1'b1;
      ready_c = 1'b1;
      start_c = 1'b1;
      @(posedge clk); #1;
      start_c = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(posedge clk); #1;
         if (fin_c === 1'b1) ok = 1'b1;
      end
      @(negedge clk); #1;
      checks++;
      if (!ok || n_c != 1 || lc_c != 1 || d_c !== mem_c || sum_c !== 16'(mem_c)) begin
         errors++;
         $display("FAIL single_beat: ok=%b beats=%0d lasts=%0d data=%0d sum=%0d, want 1 1 1 %0d %0d",
                  ok, n_c, lc_c, d_c, sum_c, mem_c, mem_c);
      end
   endtask

   initial begin
      for (int i = 0; i < NA; i++) mem_a[i] = 8'(10 + i);
      test_reset();
      test_wait_then_stream();
      test_stall();
      test_random_busy_start();
      test_start_with_done();
      test_reset_mid();
      test_outsize300();
      test_outsize1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
